// File: rtl/imm_encoder.sv
// RV32I instruction encoder: turns a decoded request (LI/JAL/SW/ADDI) into packed
// instruction words on a valid/ready stream; LI expands to LUI and/or ADDI.
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a beat/request transfers on a rising edge where valid & ready are
  // both high; out_* hold stable while out_valid=1 and out_ready=0.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT1 = 2'd1;
  localparam logic [1:0] ST_BEAT2 = 2'd2;

  localparam logic [1:0] OP_LI   = 2'd0;
  localparam logic [1:0] OP_JAL  = 2'd1;
  localparam logic [1:0] OP_SW   = 2'd2;
  localparam logic [1:0] OP_ADDI = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] second_q, second_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic        fits12, fits_jal;
  logic [31:0] hi_sum;
  logic [11:0] lo;
  logic [31:0] lui_w;
  logic [31:0] enc_first, enc_second;
  logic        enc_two, enc_err;
  logic        accept, out_hs;

  assign fits12   = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits_jal = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
  // Rounding the upper part up compensates for ADDI sign-extending lo.
  assign hi_sum   = in_imm + 32'h0000_0800;
  assign lo       = in_imm[11:0];
  assign lui_w    = {hi_sum[31:12], in_rd, 7'h37};

  always_comb begin
    enc_first  = NOP;
    enc_second = '0;
    enc_two    = 1'b0;
    enc_err    = 1'b0;
    case (in_op)
      OP_LI: begin
        if (fits12) begin
          enc_first = {lo, 5'd0, 3'b000, in_rd, 7'h13};
        end else if (lo == 12'd0) begin
          enc_first = lui_w;
        end else begin
          enc_first  = lui_w;
          enc_second = {lo, in_rd, 3'b000, in_rd, 7'h13};
          enc_two    = 1'b1;
        end
      end
      OP_JAL: begin
        if (fits_jal) enc_first = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
        else          enc_err   = 1'b1;
      end
      OP_SW: begin
        if (fits12) enc_first = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'h23};
        else        enc_err   = 1'b1;
      end
      OP_ADDI: begin
        if (fits12) enc_first = {lo, in_rs1, 3'b000, in_rd, 7'h13};
        else        enc_err   = 1'b1;
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign out_valid   = (state_q != ST_IDLE);
  assign out_instr   = instr_q;
  assign out_last    = last_q;
  assign out_err     = err_q;
  assign dbg_state_o = state_q;

  assign out_hs   = out_valid & out_ready;
  assign in_ready = (state_q == ST_IDLE) | (out_hs & last_q);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    second_d = second_q;
    last_d   = last_q;
    err_d    = err_q;
    if (accept) begin
      state_d  = ST_BEAT1;
      instr_d  = enc_first;
      second_d = enc_second;
      last_d   = !enc_two;
      err_d    = enc_err;
    end else if (out_hs) begin
      if (!last_q) begin
        state_d = ST_BEAT2;
        instr_d = second_q;
        last_d  = 1'b1;
        err_d   = 1'b0;
      end else begin
        state_d = ST_IDLE;
        instr_d = '0;
        last_d  = 1'b0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      second_q <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      second_q <= second_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors with known words, then randomized requests
// under random backpressure checked against an arithmetic reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;
  logic [1:0]  dbg_state;

  logic        rand_rdy = 1'b0;
  logic        fix_rdy  = 1'b1;
  logic        rnd_rdy  = 1'b1;
  assign out_ready = rand_rdy ? rnd_rdy : fix_rdy;

  imm_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .out_err(out_err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  int checks = 0;
  int errs   = 0;
  logic [33:0] exp_q[$];   // {err, last, instr}
  int beat_cyc[$];

  task automatic check_val(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every accepted beat is compared with the head of exp_q
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) check_val("unexpected_beat", {out_err, out_last, out_instr}, 34'h3_FFFF_FFFF);
      else check_val("beat", {out_err, out_last, out_instr}, exp_q.pop_front());
    end
  end

  // reference model: derived from the arithmetic meaning of the immediate
  function automatic void model(input logic [1:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [31:0] imm);
    longint sv, lo, hi;
    logic [11:0] lo12;
    logic [19:0] h;
    sv = longint'($signed(imm));
    case (op)
      2'd0: begin
        lo   = ((sv + 2048) % 4096 + 4096) % 4096 - 2048;
        hi   = (sv - lo) / 4096;
        lo12 = 12'(lo);
        h    = 20'(hi);
        if (sv >= -2048 && sv <= 2047) exp_q.push_back({2'b01, lo12, 5'd0, 3'd0, rd, 7'h13});
        else if (lo == 0) exp_q.push_back({2'b01, h, rd, 7'h37});
        else begin
          exp_q.push_back({2'b00, h, rd, 7'h37});
          exp_q.push_back({2'b01, lo12, rd, 3'd0, rd, 7'h13});
        end
      end
      2'd1: begin
        if (sv < -(64'sd1 << 20) || sv > (64'sd1 << 20) - 2 || (sv % 2) != 0)
          exp_q.push_back({2'b11, 32'h13});
        else exp_q.push_back({2'b01, imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F});
      end
      2'd2: begin
        if (sv < -2048 || sv > 2047) exp_q.push_back({2'b11, 32'h13});
        else exp_q.push_back({2'b01, imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23});
      end
      default: begin
        if (sv < -2048 || sv > 2047) exp_q.push_back({2'b11, 32'h13});
        else exp_q.push_back({2'b01, imm[11:0], rs1, 3'd0, rd, 7'h13});
      end
    endcase
  endfunction

  // driver: presents a request and returns just after the accepting edge
  task automatic send(input logic [1:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check_val("accept_timeout", 34'(n), 34'd0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_imm   = $urandom;
    in_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("drain_left", 34'(exp_q.size()), 34'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] bnd[14];
    bnd = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd1048574, 32'd1048575,
            -32'sd1048576, -32'sd1048578, 32'd1048576, 32'h7FFF_FFFF, 32'h8000_0000,
            32'h7FFF_F800, 32'd0, 32'hFFFF_FFFF};
    case ($urandom_range(0, 4))
      0: return $urandom_range(0, 4095) - 32'd2048;
      1: return $urandom;
      2: return bnd[$urandom_range(0, 13)];
      3: return $urandom & 32'hFFFF_F000;
      default: return $urandom_range(0, 2097151) - 32'd1048576;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", 34'(out_valid), 34'd0);
    check_val("rst_out_last", 34'(out_last), 34'd0);
    check_val("rst_out_err", 34'(out_err), 34'd0);
    check_val("rst_out_instr", 34'(out_instr), 34'd0);
    check_val("rst_in_ready", 34'(in_ready), 34'd1);
    @(posedge clk); #1;

    // directed vectors with known encodings
    exp_q.push_back({2'b00, 32'h1234_52B7}); exp_q.push_back({2'b01, 32'h6782_8293});
    send(2'd0, 5'd5, 5'd9, 5'd9, 32'h1234_5678); idle();
    exp_q.push_back({2'b01, 32'h8000_0093});
    send(2'd0, 5'd1, 5'd7, 5'd0, 32'hFFFF_F800); idle();
    exp_q.push_back({2'b01, 32'h0000_1137});
    send(2'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1000); idle();
    exp_q.push_back({2'b00, 32'h0000_11B7}); exp_q.push_back({2'b01, 32'h8001_8193});
    send(2'd0, 5'd3, 5'd0, 5'd0, 32'h0000_0800); idle();
    exp_q.push_back({2'b01, 32'h0080_00EF});
    send(2'd1, 5'd1, 5'd0, 5'd0, 32'd8); idle();
    exp_q.push_back({2'b01, 32'h0051_2623});
    send(2'd2, 5'd0, 5'd2, 5'd5, 32'd12); idle();
    exp_q.push_back({2'b11, 32'h0000_0013});
    send(2'd3, 5'd1, 5'd0, 5'd0, 32'd2048); idle();
    exp_q.push_back({2'b11, 32'h0000_0013});
    send(2'd1, 5'd1, 5'd0, 5'd0, 32'd3); idle();
    wait_drain();

    // backpressure during beat 1 of a two-beat LI
    fix_rdy = 1'b0;
    exp_q.push_back({2'b00, 32'h1234_52B7}); exp_q.push_back({2'b01, 32'h6782_8293});
    send(2'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678); idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_hold", {out_valid, in_ready, out_instr}, {2'b10, 32'h1234_52B7});
    end
    fix_rdy = 1'b1;
    wait_drain();

    // reset while the second LI beat is presented
    exp_q.push_back({2'b00, 32'h1234_52B7});
    send(2'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678); idle();
    @(posedge clk); #1;
    check_val("b2_present", {out_valid, out_last, out_instr}, {2'b11, 32'h6782_8293});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_b2_valid", 34'(out_valid), 34'd0);
    check_val("rst_b2_ready", 34'(in_ready), 34'd1);
    repeat (6) @(posedge clk);
    #1;
    check_val("rst_b2_queue", 34'(exp_q.size()), 34'd0);

    // back-to-back streaming, expected one beat per cycle
    beat_cyc.delete();
    exp_q.push_back({2'b01, 32'h0080_00EF});
    exp_q.push_back({2'b00, 32'h1234_52B7}); exp_q.push_back({2'b01, 32'h6782_8293});
    exp_q.push_back({2'b01, 32'h0051_2623});
    exp_q.push_back({2'b01, 32'h0050_0093});
    send(2'd1, 5'd1, 5'd0, 5'd0, 32'd8);
    send(2'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    send(2'd2, 5'd0, 5'd2, 5'd5, 32'd12);
    send(2'd3, 5'd1, 5'd0, 5'd0, 32'd5);
    idle();
    wait_drain();
    check_val("stream_beats", 34'(beat_cyc.size()), 34'd5);
    if (beat_cyc.size() >= 5) check_val("stream_span", 34'(beat_cyc[4] - beat_cyc[0]), 34'd4);

    // randomized requests under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [4:0] rd, rs1, rs2;
      logic [31:0] imm;
      op = 2'($urandom_range(0, 3));
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      imm = rand_imm();
      model(op, rd, rs1, rs2, imm);
      send(op, rd, rs1, rs2, imm);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    wait_drain();
    rand_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Immediate/instruction encoder: the inverse of the immediate-extraction path. It accepts a decoded request (op, register fields, 32-bit immediate) and emits packed RV32I instruction words over a valid/ready stream. The LI pseudo-op expands to one or two words (LUI/ADDI). It sits between the debug/boot instruction-injection logic and the fetch-side instruction buffer.

## Interface
Parameters: none.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid & in_ready at a clock edge
- in_op  in  2  0=LI, 1=JAL, 2=SW, 3=ADDI
- in_rd  in  5  destination register (LI, JAL, ADDI)
- in_rs1  in  5  base/source register (SW, ADDI); ignored for LI and JAL
- in_rs2  in  5  store data register (SW)
- in_imm  in  32  immediate, two's complement
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts beat when out_valid & out_ready
- out_instr  out  32  encoded instruction word
- out_last  out  1  final beat of the current request
- out_err  out  1  request immediate out of range; beat carries NOP

## Operation
- Encodings (v = in_imm):
  - ADDI: {v[11:0], rs1, 3'b000, rd, 7'h13}.
  - SW: {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'h23}.
  - JAL: {v[20], v[10:1], v[11], v[19:12], rd, 7'h6F}.
  - LUI: {hi[19:0], rd, 7'h37}.
- Range checks: ADDI and SW need -2048 <= v <= 2047. JAL needs -2^20 <= v <= 2^20-2 and v[0]=0. On a violation, emit one beat: out_instr=32'h00000013, out_err=1, out_last=1.
- LI expansion. Let hi=(v+32'h800)[31:12] (32-bit wrap) and lo=v[11:0].
  - If -2048 <= v <= 2047: single beat ADDI rd,x0,lo.
  - Else if lo==0: single beat LUI rd,hi.
  - Else: two beats, LUI rd,hi then ADDI rd,rd,lo.
  - LI never errors.
- All request fields are registered on acceptance. Later changes on the in_* pins have no effect on the request in progress.
- FSM:
  - IDLE: out_valid=0. On accept, go to BEAT1.
  - BEAT1: first word presented. On an out handshake, go to BEAT2 if the request is a two-beat LI. Otherwise go to IDLE, or stay in BEAT1 if a new request is accepted in the same cycle.
  - BEAT2: ADDI word presented with out_last=1. On handshake, go to IDLE, or to BEAT1 if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
- reset in any state goes to IDLE. Any in-flight beats, including a pending second LI beat, are discarded.

## Timing
- Reset values: out_valid=0, out_last=0, out_err=0, out_instr=0. in_ready=1 in the cycle after reset deasserts.
- Latency: a request accepted at edge N presents its first beat from edge N to N+1 (out_valid=1 in cycle N+1). No combinational in->out path.
- Throughput: one beat per cycle with out_ready held high. Back-to-back requests need no bubble, because in_ready is asserted during the last-beat handshake.
- Backpressure: while out_valid=1 and out_ready=0, out_instr, out_last and out_err hold stable and in_ready=0 (unless state is IDLE).
- out_err and out_last are only meaningful while out_valid=1. Both are 0 in IDLE.
- in_ready depends combinationally on out_ready. out_valid/out_instr/out_last/out_err are registered only.

## Test plan
- LI x5, 0x12345678, out_ready=1. Expected: beat 1 = 0x123452B7 (last=0), beat 2 = 0x67828293 (last=1), err=0 on both.
- LI x1, 0xFFFFF800 gives one beat, 0x80000093 (last=1). LI x2, 0x00001000 gives one beat, 0x00001137 (last=1).
- LI x3, 0x00000800 (carry case) gives 0x000011B7 then 0x80018193.
- JAL x1,+8 gives 0x008000EF. SW x5,12(x2) gives 0x00512623. ADDI x1,x0,2048 gives 0x00000013 with err=1, last=1. JAL imm=3 gives NOP with err=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles during beat 1 of an LI. out_instr must stay 0x123452B7 and in_ready must stay 0. Then release out_ready.
  - Assert reset during BEAT2. Next cycle: out_valid=0, in_ready=1, and no second beat is ever emitted.
- Streaming: issue 4 back-to-back requests (JAL, LI two-beat, SW, ADDI) with in_valid and out_ready held at 1. Expect 5 beats in 5 consecutive cycles with no idle cycles, with out_last asserted on beats 1, 3, 4 and 5.
